// File: rtl/regfile_sb.sv
// Multi-ported register file with an integrated pending-write scoreboard.
// Reads are combinational; writes, reservations, releases and flush land on the rising edge.
module regfile_sb #(
  parameter  int NUM_REGS = 32,
  parameter  int DATA_W   = 32,
  parameter  int NUM_RD   = 3,
  parameter  int NUM_WR   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_RD*AW-1:0]     rsel,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid,
  input  logic [NUM_WR-1:0]        wen,
  input  logic [NUM_WR*AW-1:0]     wsel,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_sel,
  output logic                     rsv_ready,
  input  logic                     flush,
  output logic [NUM_REGS-1:0]      pending
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] wr_hit;
  logic                rsv_zero;
  logic                rsv_ok;

  // Ports are applied in ascending order so the highest-indexed writer wins.
  always_comb begin
    regs_d = regs_q;
    wr_hit = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wen[j] && !(ZR && (wsel[j*AW +: AW] == '0))) begin
        regs_d[wsel[j*AW +: AW]] = wdata[j*DATA_W +: DATA_W];
        wr_hit[wsel[j*AW +: AW]] = 1'b1;
      end
    end
  end

  // Reserve handshake: rsv_en is the request, rsv_ready the grant; a reservation
  // takes effect on an edge where both are high, otherwise the requester holds
  // rsv_en/rsv_sel stable and retries. A same-cycle writeback frees the slot.
  always_comb begin
    rsv_zero  = ZR && (rsv_sel == '0);
    rsv_ok    = rsv_zero || !pending_q[rsv_sel] || wr_hit[rsv_sel];
    rsv_ready = rsv_ok;
    pending_d = pending_q & ~wr_hit;
    if (rsv_en && rsv_ok && !rsv_zero) begin
      pending_d[rsv_sel] = 1'b1;
    end
    if (flush) begin
      pending_d = '0;
    end
  end

  // Bypass beats the stored value, zero register beats everything, and reset
  // forces the idle read view even while a write is still being driven.
  always_comb begin
    rdata  = '0;
    rvalid = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rdata[i*DATA_W +: DATA_W] = regs_q[rsel[i*AW +: AW]];
      rvalid[i]                 = !pending_q[rsel[i*AW +: AW]];
      if (BP) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wen[j] && (wsel[j*AW +: AW] == rsel[i*AW +: AW])) begin
            rdata[i*DATA_W +: DATA_W] = wdata[j*DATA_W +: DATA_W];
            rvalid[i]                 = 1'b1;
          end
        end
      end
      if ((ZR && (rsel[i*AW +: AW] == '0)) || RST) begin
        rdata[i*DATA_W +: DATA_W] = '0;
        rvalid[i]                 = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the scalar register file, sized for the tensor-core datapath.
- Configurable register count, data width, read-port count and write-port count.
- Optional hardwired zero register and optional same-cycle write-to-read bypass.
- Integrated pending-write scoreboard: issue reserves a destination, writeback releases it, and each read reports whether its data is valid.

Parameters:
NUM_REGS, 32, number of registers (power of 2, >=2); AW = $clog2(NUM_REGS)
DATA_W, 32, register width in bits
NUM_RD, 3, read-port count (>=1)
NUM_WR, 2, write-port count (>=1)
ZERO_REG, 1, 1 = reg 0 reads 0, ignores writes, is never pending
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous, active-high reset
rsel  in  NUM_RD*AW  read selects; port i = bits [i*AW +: AW]
rdata  out  NUM_RD*DATA_W  read data, packed like rsel
rvalid  out  NUM_RD  1 = rdata[i] holds the committed value (target not pending)
wen  in  NUM_WR  write enables
wsel  in  NUM_WR*AW  write selects
wdata  in  NUM_WR*DATA_W  write data
rsv_en  in  1  reserve request (mark destination pending)
rsv_sel  in  AW  register to reserve
rsv_ready  out  1  1 = reserve accepted this cycle
flush  in  1  clear all pending bits
pending  out  NUM_REGS  scoreboard state, bit r = register r pending

Behaviour:
- Reset (RST high, asynchronous):
  - All registers = 0 and pending = 0.
  - Outputs: rsv_ready = 1; rvalid = all 1; rdata = 0.
  - Reset asserted mid-operation discards in-flight reservations and writes that cycle.
- Write:
  - wen[j] with wsel[j] updates the register at the next rising edge.
  - Un-bypassed reads see the new value from the following cycle.
  - Two write ports targeting the same register in one cycle: the highest port index wins.
  - ZERO_REG=1 and wsel=0: write dropped.
- Write release: a write to register r clears pending[r] at the same edge.
- Read (combinational from rsel):
  - rdata[i] = reg[rsel[i]].
  - ZERO_REG=1 and rsel[i]=0: rdata=0, rvalid=1.
  - BYPASS=1 and some wen[j] with wsel[j]==rsel[i]: rdata[i] = wdata of the highest such j, rvalid[i]=1.
  - Otherwise rvalid[i] = ~pending[rsel[i]].
  - BYPASS=0: same-cycle written values are not forwarded; rvalid[i] = ~pending[rsel[i]].
- Reserve:
  - rsv_ready = ~pending[rsv_sel] OR (a write to rsv_sel this cycle).
  - rsv_en & rsv_ready: pending[rsv_sel] set at the edge. This wins over a same-cycle release of the same register (new producer); the write data still commits.
  - rsv_en & ~rsv_ready: ignored, no state change. Requester must hold the request and retry (WAW stall).
  - ZERO_REG=1 and rsv_sel=0: rsv_ready=1, no state change.
- Flush: clears all pending bits at the edge and overrides a same-cycle reserve. Same-cycle writes still commit.
- Timing: no other state, no multi-cycle latency. Read path is combinational; writes, reserves and releases take effect after 1 edge.
- Index rules:
  - sel values >= NUM_REGS cannot occur, since NUM_REGS is a power of 2.
  - Widths are exact: no sign or zero extension anywhere.

Test Plan:
- Reset, then read ports 0..2 at regs 1,2,3 -> rdata=0, rvalid=3'b111, rsv_ready=1, pending=0.
- Write port0 reg5=0xDEADBEEF, port1 reg5=0x12345678 same cycle; next cycle read reg5 -> 0x12345678. Write reg0=0xFFFF_FFFF -> reads 0.
- BYPASS=1: reserve reg7, next cycle read reg7 -> rvalid=0. Write reg7=0xA5A5A5A5 while reading it -> rdata=0xA5A5A5A5, rvalid=1 that cycle; pending[7]=0 after the edge.
- Reserve reg9, then reserve reg9 again with no write -> rsv_ready=0 and pending unchanged. Re-reserve in the same cycle as a write to reg9 -> accepted; pending[9] stays 1 and reg9 holds the written data.
- Reserve regs 3, 4, 6, then assert flush together with rsv_en on reg10 -> pending=0 after the edge (reg10 not reserved).
- Reserve reg2, write reg2=0x55, assert RST asynchronously between edges -> immediately reg2 reads 0, pending=0, rvalid all 1.
